// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin 4:1 mux arbiter: state encoding, index type
// and the rotating-priority pick function.
package mux_arb_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). Walking the offsets
  // downwards lets the nearest set bit be the last one written.
  function automatic pick_t rr_pick(input logic [3:0] mask, input idx_t ptr);
    pick_t res;
    idx_t  cand;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + idx_t'(k);
      if (mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data bundle between the requesters, the arbiter and the consumers
// of the muxed bit.
interface mux_arb_if;
  import mux_arb_pkg::*;

  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       d;
  logic       d_valid;
  idx_t       d_src;

  modport master (
    output req, i,
    input  gnt, s1, s0, d, d_valid, d_src
  );

  modport slave (
    input  req, i,
    output gnt, s1, s0, d, d_valid, d_src
  );
endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// Plain combinational 4:1 one-bit multiplexer driven by the arbiter's
// registered selects.
module mux_4to1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic d
);
  assign d = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// bounded hold time per owner and a registered data/valid/source stage.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic     clk,
  input logic     rst_n,
  mux_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  idx_t             ptr_q, ptr_d;
  idx_t             own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             d_q, d_valid_q;
  idx_t             d_src_q;
  logic             mux_out;
  logic [3:0]       others;
  pick_t            pick_any, pick_oth;

  assign others   = bus.req & ~(4'b0001 << own_q);
  assign pick_any = rr_pick(bus.req, ptr_q);
  assign pick_oth = rr_pick(others, ptr_q);

  // NOTE: every next-state signal gets a default first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        gnt_d = '0;
        if (pick_any.found) begin
          state_d = ST_GRANT;
          own_d   = pick_any.idx;
          ptr_d   = pick_any.idx + 1'b1;
          gnt_d   = 4'b0001 << pick_any.idx;
        end
      end
      ST_GRANT: begin
        if (pick_oth.found && (!bus.req[own_q] || cnt_q == HOLD_LAST)) begin
          own_d = pick_oth.idx;
          ptr_d = pick_oth.idx + 1'b1;
          cnt_d = '0;
          gnt_d = 4'b0001 << pick_oth.idx;
        end else if (bus.req[own_q]) begin
          // Saturate so a lone owner is handed off as soon as anyone else asks.
          if (cnt_q < HOLD_LAST) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  mux_4to1 u_mux (
    .i0 (bus.i[0]),
    .i1 (bus.i[1]),
    .i2 (bus.i[2]),
    .i3 (bus.i[3]),
    .s0 (own_q[0]),
    .s1 (own_q[1]),
    .d  (mux_out)
  );

  // Data stage trails the grant by one cycle and reflects the selection in force.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= 1'b0;
      d_valid_q <= 1'b0;
      d_src_q   <= '0;
    end else begin
      d_q       <= mux_out;
      d_valid_q <= (state_q == ST_GRANT);
      d_src_q   <= own_q;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s1      = own_q[1];
  assign bus.s0      = own_q[0];
  assign bus.d       = d_q;
  assign bus.d_valid = d_valid_q;
  assign bus.d_src   = d_src_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares a single 4:1 one-bit mux among four requesters. It takes four request lines and the four data bits, and grants exactly one requester at a time. It drives the mux selects from the grant and registers the selected bit together with a valid flag and a source tag. The block sits between the requester logic and downstream consumers of the muxed bit, replacing hand-driven s1/s0 selects.

## Interface
- HOLD_CYCLES, default 4: maximum consecutive grant cycles for one owner while another request is pending; legal range 1..255.
- CNT_W, default 8: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request level per requester; bit n belongs to requester n.
- i  input  4  data bit per requester; i[n] feeds mux input n.
- gnt  output  4  one-hot grant, or all zero when idle; registered.
- s1, s0  output  1 each  mux selects, equal to the binary index of the granted requester; registered.
- d  output  1  registered mux output.
- d_valid  output  1  d holds a granted requester's bit.
- d_src  output  2  index of the requester that produced d.

## Operation
- States:
  - IDLE: gnt=0, counter cleared.
  - GRANT: exactly one gnt bit set.
- Priority pointer ptr (2 bits) names the first index searched. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4. On every new grant, ptr becomes owner+1 mod 4.
- IDLE -> GRANT when any req bit is set. The owner is the first set bit in search order.
- GRANT -> GRANT (switch) in either case, when at least one other req bit is set:
  - req[owner] has dropped, or
  - the counter has reached HOLD_CYCLES-1.
  - The new owner is the first other set bit in search order. No idle bubble occurs between owners.
- GRANT -> GRANT (stay) when req[owner] is high and either:
  - the counter is below HOLD_CYCLES-1, or
  - no other request is pending. In this case the counter saturates at HOLD_CYCLES-1.
- GRANT -> IDLE when req[owner] has dropped and no other req bit is set.
- Counter behaviour:
  - Increments each cycle the owner is held.
  - Clears on every switch and on entry to GRANT.
- {s1,s0} always equals the encoded owner. They hold their last value while in IDLE.
- Datapath, registered every cycle:
  - d <= i[{s1,s0}] (mux output).
  - d_valid <= (state==GRANT).
  - d_src <= {s1,s0}.
- req bits that change between edges have no effect; only values sampled at the edge matter.

## Timing
- Reset values (rst_n low, asynchronous):
  - gnt=4'b0000, s1=s0=0, d=0, d_valid=0, d_src=0.
  - state=IDLE, ptr=0, counter=0.
- Reset release: the first edge with rst_n high may already grant.
- Request to grant latency: 1 cycle. A req set before edge k gives gnt asserted after edge k.
- Grant to data latency: 1 further cycle. d/d_valid/d_src reflect the selection active during cycle k+1 after edge k+1.
- Release latency: 1 cycle. Dropping req before edge k clears or moves gnt after edge k. d_valid falls one cycle after gnt clears.
- Maximum continuous ownership under contention is exactly HOLD_CYCLES cycles. With HOLD_CYCLES=1, ownership rotates every cycle.
- Simultaneous owner release and a new request: the switch goes straight to the new owner.
- Reset asserted mid-grant: all outputs clear immediately, with no wait for clk.

## Structure
- Shared package (mux_arb_pkg):
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - The 2-bit index width.
  - A function for the round-robin pick, taking a 4-bit mask and a 2-bit ptr and returning a found flag and a 2-bit index.
- Sub-module mux_4to1: ports i0..i3, s0, s1, d; purely combinational. Instantiated once, fed by the registered selects.
- Everything else lives in one file: the FSM, ptr, counter and output registers.

## Test plan
- Reset check: rst_n low with req=4'b1111 -> all outputs 0. Release rst_n -> gnt=4'b0001 after the first edge, and d_valid=1 one edge later.
- Single requester: req=4'b0100 with i=4'b0100 -> gnt=4'b0100 and {s1,s0}=2'b10 after 1 edge, then d=1 and d_src=2 after 2 edges. Drop req -> gnt=0 after 1 edge.
- Contention with HOLD_CYCLES=4 and req=4'b1111 held -> grants rotate 0,1,2,3,0, each held exactly 4 cycles, with no cycle of gnt=0.
- Early release: owner 1 drops req in its 2nd cycle while req[3] is pending and req[2] is low -> gnt moves to 4'b1000 on the next edge, and the counter restarts.
- Solo saturation: only req[2] high for 20 cycles -> gnt stays at 4'b0100 throughout. When req[0] then rises -> gnt=4'b0001 after 1 edge.
- Async reset mid-grant: assert rst_n low between clock edges during a grant to requester 3 -> gnt, d_valid and the selects clear before the next edge. After release, the first grant follows ptr=0.
